// File: rtl/osc_meas_scheduler_pkg.sv
// Shared types and constants for the ring-oscillator measurement sequencer.
// Imported by the result interface, the window timer and the scheduler top.
package meas_pkg;

    localparam int NUM_OSC = 2;

    typedef logic osc_idx_t;

    localparam osc_idx_t OSC_INV  = 1'b0;
    localparam osc_idx_t OSC_NAND = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        COUNT,
        CAPTURE,
        REPORT,
        GAP
    } state_t;

    // The inverter oscillator always runs first when both are selected.
    function automatic osc_idx_t first_osc(input logic [NUM_OSC-1:0] mask);
        return mask[OSC_INV] ? OSC_INV : OSC_NAND;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/osc_meas_scheduler_if.sv
// Result handshake from the measurement sequencer to the UART/threshold side.
// The producer holds every payload field stable while res_valid is high.
interface osc_meas_scheduler_if
    import meas_pkg::*;
#(
    parameter int CNT_W = 10
);

    logic [CNT_W-1:0] res_value;
    osc_idx_t         res_osc;
    logic             res_sat;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output res_value,
        output res_osc,
        output res_sat,
        output res_valid,
        input  res_ready
    );

    modport slave (
        input  res_value,
        input  res_osc,
        input  res_sat,
        input  res_valid,
        output res_ready
    );

endinterface

// File: rtl/osc_meas_scheduler_timer.sv
// Loadable down-counter shared by the SETTLE, COUNT and GAP phases.
// Loaded with (duration - 1); done is high on the last cycle of the phase.
module meas_timer #(
    parameter int TW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          run,
    output logic          done
);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - TW'(1);
        end
    end

    assign done = run && (cnt_q == '0);

endmodule

// File: rtl/osc_meas_scheduler.sv
// Measurement sequencer: settles each selected ring oscillator, gates the shared
// edge counter over fixed windows, averages 2^LOG2_AVG counts and reports them.
module osc_meas_scheduler
    import meas_pkg::*;
#(
    parameter int CNT_W         = 10,
    parameter int WIN_CYCLES    = 1000,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOG2_AVG      = 2,
    parameter int IDLE_CYCLES   = 10000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 auto_mode,
    input  logic                 abort,
    input  logic [NUM_OSC-1:0]   osc_mask,
    input  logic [CNT_W-1:0]     cnt_val,
    output logic [NUM_OSC-1:0]   osc_en,
    output logic                 osc_sel,
    output logic                 cnt_en,
    output logic                 cnt_clr,
    output logic                 busy,
    osc_meas_scheduler_if.master res
);

    localparam int ACC_W   = CNT_W + LOG2_AVG;
    localparam int SMP_W   = LOG2_AVG + 1;
    localparam int MAX_CYC = max3(WIN_CYCLES, SETTLE_CYCLES, IDLE_CYCLES);
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_t           state_q, state_d;
    osc_idx_t         osc_q, osc_d;
    logic             nand_q;
    logic [ACC_W-1:0] acc_q;
    logic             sat_q;
    logic [SMP_W-1:0] smp_q;

    logic             latch_mask;
    logic             xfer;
    logic             timer_load;
    logic [TW-1:0]    timer_val;
    logic             timer_run;
    logic             timer_done;
    logic             active;

    meas_timer #(
        .TW (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .run      (timer_run),
        .done     (timer_done)
    );

    assign timer_run = (state_q == SETTLE) || (state_q == COUNT) || (state_q == GAP);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through
        // the case statement can leave it unassigned and infer a latch.
        state_d    = state_q;
        osc_d      = osc_q;
        latch_mask = 1'b0;
        xfer       = 1'b0;
        timer_val  = '0;

        unique case (state_q)
            IDLE: begin
                if ((start || auto_mode) && (osc_mask != '0)) begin
                    state_d    = SETTLE;
                    latch_mask = 1'b1;
                    osc_d      = first_osc(osc_mask);
                end
            end
            SETTLE: begin
                if (timer_done) state_d = COUNT;
            end
            COUNT: begin
                if (timer_done) state_d = CAPTURE;
            end
            CAPTURE: begin
                // smp_q still holds the pre-increment count on this cycle.
                state_d = (smp_q == SMP_W'((1 << LOG2_AVG) - 1)) ? REPORT : COUNT;
            end
            REPORT: begin
                if (res.res_ready) begin
                    xfer = 1'b1;
                    if ((osc_q == OSC_INV) && nand_q) begin
                        state_d = SETTLE;
                        osc_d   = OSC_NAND;
                    end else if (auto_mode) begin
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (timer_done) begin
                    if (auto_mode && (osc_mask != '0)) begin
                        state_d    = SETTLE;
                        latch_mask = 1'b1;
                        osc_d      = first_osc(osc_mask);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d    = IDLE;
            latch_mask = 1'b0;
            xfer       = 1'b0;
        end

        unique case (state_d)
            SETTLE:  timer_val = TW'(SETTLE_CYCLES - 1);
            COUNT:   timer_val = TW'(WIN_CYCLES - 1);
            GAP:     timer_val = TW'(IDLE_CYCLES - 1);
            default: timer_val = '0;
        endcase
    end

    // Every entry into a timed phase, including CAPTURE back to COUNT, reloads the timer.
    assign timer_load = (state_d != state_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            // Abort discards the round, including any pending result, just like reset.
            state_q <= IDLE;
            osc_q   <= OSC_INV;
            nand_q  <= 1'b0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            smp_q   <= '0;
        end else begin
            state_q <= state_d;
            osc_q   <= osc_d;
            if (latch_mask) nand_q <= osc_mask[OSC_NAND];
            if (xfer) begin
                acc_q <= '0;
                sat_q <= 1'b0;
                smp_q <= '0;
            end else if (state_q == CAPTURE) begin
                acc_q <= acc_q + ACC_W'(cnt_val);
                sat_q <= sat_q || (cnt_val == '1);
                smp_q <= smp_q + SMP_W'(1);
            end
        end
    end

    assign active  = (state_q == SETTLE) || (state_q == COUNT) ||
                     (state_q == CAPTURE) || (state_q == REPORT);
    assign osc_en  = active ? (NUM_OSC'(1) << osc_q) : '0;
    assign osc_sel = active && (osc_q == OSC_NAND);
    assign cnt_en  = (state_q == COUNT);
    assign cnt_clr = (state_q == SETTLE) || (state_q == CAPTURE);
    assign busy    = (state_q != IDLE);

    // Payload comes straight from registers that only change on the transfer edge.
    assign res.res_valid = (state_q == REPORT);
    assign res.res_value = res.res_valid ? CNT_W'(acc_q >> LOG2_AVG) : '0;
    assign res.res_osc   = res.res_valid && osc_q;
    assign res.res_sat   = res.res_valid && sat_q;

endmodule

// File: tb/tb_osc_meas_scheduler.sv
// Directed bench for osc_meas_scheduler: table of full rounds plus hand-written
// sequences for backpressure, auto mode, abort, reset and an empty mask.
module tb_osc_meas_scheduler;
    import meas_pkg::*;

    localparam int CNT_W = 10;
    localparam int W     = 8;
    localparam int S     = 4;
    localparam int L     = 2;
    localparam int G     = 5;

    logic             clk = 1'b0;
    logic             rst, start, auto_mode, abort;
    logic [1:0]       osc_mask;
    logic [CNT_W-1:0] cnt_val;
    logic [1:0]       osc_en;
    logic             osc_sel, cnt_en, cnt_clr, busy;

    osc_meas_scheduler_if #(.CNT_W(CNT_W)) res_if ();

    osc_meas_scheduler #(
        .CNT_W         (CNT_W),
        .WIN_CYCLES    (W),
        .SETTLE_CYCLES (S),
        .LOG2_AVG      (L),
        .IDLE_CYCLES   (G)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .auto_mode (auto_mode),
        .abort     (abort),
        .osc_mask  (osc_mask),
        .cnt_val   (cnt_val),
        .osc_en    (osc_en),
        .osc_sel   (osc_sel),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .busy      (busy),
        .res       (res_if)
    );

    always #5 clk = ~clk;

    // Edge-counter model: each window's count is loaded on the first gated cycle.
    logic [7:0][CNT_W-1:0] model_smp;
    logic [2:0]            model_idx;
    logic                  model_idx_clr;
    logic                  en_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_val   <= '0;
            model_idx <= '0;
            en_prev   <= 1'b0;
        end else begin
            en_prev <= cnt_en;
            if (cnt_clr) cnt_val <= '0;
            else if (cnt_en && !en_prev) cnt_val <= model_smp[model_idx];
            if (model_idx_clr) model_idx <= '0;
            else if (cnt_en && !en_prev) model_idx <= model_idx + 3'd1;
        end
    end

    typedef struct packed {
        logic [1:0]            mask;
        logic [7:0][CNT_W-1:0] smp;
        logic [1:0]            nres;
        logic [1:0][CNT_W-1:0] val;
        logic [1:0]            osc;
        logic [1:0]            sat;
        logic [1:0][7:0]       vcyc;
    } vec_t;

    vec_t vecs [4];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    function automatic vec_t mk(input logic [1:0] m, input int a0, input int a1, input int a2,
                                input int a3, input int a4, input int a5, input int a6,
                                input int a7, input int n, input int v0, input int o0,
                                input int s0, input int c0, input int v1, input int o1,
                                input int s1, input int c1);
        vec_t r;
        r.mask    = m;
        r.smp[0]  = a0[CNT_W-1:0];
        r.smp[1]  = a1[CNT_W-1:0];
        r.smp[2]  = a2[CNT_W-1:0];
        r.smp[3]  = a3[CNT_W-1:0];
        r.smp[4]  = a4[CNT_W-1:0];
        r.smp[5]  = a5[CNT_W-1:0];
        r.smp[6]  = a6[CNT_W-1:0];
        r.smp[7]  = a7[CNT_W-1:0];
        r.nres    = n[1:0];
        r.val[0]  = v0[CNT_W-1:0];
        r.val[1]  = v1[CNT_W-1:0];
        r.osc     = {o1[0], o0[0]};
        r.sat     = {s1[0], s0[0]};
        r.vcyc[0] = c0[7:0];
        r.vcyc[1] = c1[7:0];
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Samples start at the next edge (edge 0); afterwards cyc = 1 is the first SETTLE cycle.
    task automatic begin_round(input logic [1:0] m, input logic [7:0][CNT_W-1:0] smp,
                               input logic do_start);
        osc_mask      = m;
        model_smp     = smp;
        model_idx_clr = 1'b1;
        start         = do_start;
        cyc           = 0;
        step();
        start         = 1'b0;
        model_idx_clr = 1'b0;
    endtask

    task automatic wait_valid(output int c);
        int n;
        n = 0;
        while (!res_if.res_valid && n < 200) begin
            step();
            n++;
        end
        c = cyc;
    endtask

    task automatic count_valid(input int cycles, output int hits);
        hits = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (res_if.res_valid) hits++;
        end
    endtask

    initial begin
        int c, c1, hits;
        logic [7:0][CNT_W-1:0] smp;

        vecs[0] = mk(2'b01, 25, 25, 25, 25, 0, 0, 0, 0, 1, 25, 0, 0, 41, 0, 0, 0, 0);
        vecs[1] = mk(2'b11, 10, 11, 12, 13, 40, 40, 40, 41, 2, 11, 0, 0, 41, 40, 1, 0, 82);
        vecs[2] = mk(2'b01, 1023, 0, 0, 0, 0, 0, 0, 0, 1, 255, 0, 1, 41, 0, 0, 0, 0);
        vecs[3] = mk(2'b10, 7, 8, 9, 10, 0, 0, 0, 0, 1, 8, 1, 0, 41, 0, 0, 0, 0);

        rst = 1'b1; start = 1'b0; auto_mode = 1'b0; abort = 1'b0; osc_mask = 2'b00;
        res_if.res_ready = 1'b0; model_idx_clr = 1'b0; model_smp = '0;
        step();
        step();
        check("reset_outputs", {osc_en, osc_sel, cnt_en, cnt_clr, busy, res_if.res_valid}, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            res_if.res_ready = 1'b1;
            begin_round(vecs[i].mask, vecs[i].smp, 1'b1);
            check($sformatf("v%0d_first_osc_en", i), osc_en, vecs[i].mask[0] ? 2'b01 : 2'b10);
            for (int r = 0; r < int'(vecs[i].nres); r++) begin
                wait_valid(c);
                check($sformatf("v%0d_r%0d_valid_cycle", i, r), c, vecs[i].vcyc[r]);
                check($sformatf("v%0d_r%0d_value", i, r), res_if.res_value, vecs[i].val[r]);
                check($sformatf("v%0d_r%0d_osc", i, r), res_if.res_osc, vecs[i].osc[r]);
                check($sformatf("v%0d_r%0d_sat", i, r), res_if.res_sat, vecs[i].sat[r]);
                step();
                check($sformatf("v%0d_r%0d_valid_drop", i, r), res_if.res_valid, 0);
                if (r + 1 < int'(vecs[i].nres))
                    check($sformatf("v%0d_nand_settle", i), {osc_en, cnt_clr}, {2'b10, 1'b1});
                else
                    check($sformatf("v%0d_idle_after", i), {busy, osc_en}, 0);
            end
        end

        // Backpressure: result must stay frozen with the counter gated off.
        res_if.res_ready = 1'b0;
        smp = '0;
        smp[0] = 10'd5; smp[1] = 10'd6; smp[2] = 10'd7; smp[3] = 10'd8;
        begin_round(2'b01, smp, 1'b1);
        wait_valid(c);
        check("bp_valid_cycle", c, 41);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("bp_hold_%0d", k),
                  {res_if.res_valid, res_if.res_value, res_if.res_osc, cnt_en, osc_en},
                  {1'b1, 10'd6, 1'b0, 1'b0, 2'b01});
            if (k < 19) step();
        end
        res_if.res_ready = 1'b1;
        step();
        check("bp_after_xfer", {res_if.res_valid, busy}, 0);
        count_valid(5, hits);
        check("bp_single_transfer", hits, 0);

        // Auto mode on the NAND oscillator: exactly G dark cycles between rounds.
        smp = {8{10'd3}};
        auto_mode = 1'b1;
        begin_round(2'b10, smp, 1'b0);
        wait_valid(c1);
        check("auto_first_valid", c1, 41);
        check("auto_first_result", {res_if.res_value, res_if.res_osc}, {10'd3, 1'b1});
        step();
        hits = 0;
        while (osc_en == 2'b00 && busy && hits < 20) begin
            hits++;
            step();
        end
        check("auto_gap_len", hits, G);
        check("auto_resettle_osc_en", osc_en, 2'b10);
        wait_valid(c);
        check("auto_round_period", c - c1, G + 41);
        step();
        auto_mode = 1'b0;
        for (int k = 0; k < G - 1; k++) step();
        check("auto_gap_end_busy", {busy, osc_en}, {1'b1, 2'b00});
        step();
        check("auto_drop_idle", busy, 0);

        // Abort mid-COUNT, then a clean round proves the accumulator was wiped.
        smp = {8{10'd9}};
        begin_round(2'b01, smp, 1'b1);
        while (cyc < 20) step();
        check("abort_mid_count", cnt_en, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_outputs", {osc_en, osc_sel, cnt_en, cnt_clr, busy, res_if.res_valid,
                                res_if.res_value, res_if.res_osc, res_if.res_sat}, 0);
        count_valid(60, hits);
        check("abort_no_valid", hits, 0);

        smp = {8{10'd20}};
        begin_round(2'b01, smp, 1'b1);
        wait_valid(c);
        check("post_abort_value", {res_if.res_value, res_if.res_sat}, {10'd20, 1'b0});
        step();

        // Reset mid-COUNT.
        smp = {8{10'd9}};
        begin_round(2'b01, smp, 1'b1);
        while (cyc < 20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("reset_mid_count", {osc_en, osc_sel, cnt_en, cnt_clr, busy, res_if.res_valid}, 0);
        count_valid(60, hits);
        check("reset_no_valid", hits, 0);

        // Empty mask never starts a round.
        begin_round(2'b00, smp, 1'b1);
        hits = 0;
        for (int k = 0; k < 10; k++) begin
            if (busy || osc_en != 2'b00) hits++;
            step();
        end
        check("empty_mask_idle", hits, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/osc_meas_scheduler.md
# osc_meas_scheduler

Measurement sequencer for the ring-oscillator temperature sensor datapath. It enables each selected oscillator in turn, lets it settle, and gates the shared edge counter over fixed windows. It accumulates and averages 2^LOG2_AVG windowed counts per oscillator, then hands each result to the UART/threshold side over a valid/ready handshake. It replaces manual pin control of oscillator enables, oscillator select and averaging enable.

## Interface
- CNT_W, 10, width of the external edge counter and of `cnt_val`
- WIN_CYCLES, 1000, counting-window length in `clk` cycles (≥1)
- SETTLE_CYCLES, 16, oscillator warm-up before the first window (≥1)
- LOG2_AVG, 2, log2 of samples averaged per oscillator (0..4)
- IDLE_CYCLES, 10000, gap between rounds in auto mode (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-round request; sampled only in IDLE
- auto_mode  in  1  1 = run rounds back-to-back, separated by IDLE_CYCLES
- abort  in  1  return to IDLE next cycle from any state
- osc_mask  in  2  bit0 = inverter oscillator, bit1 = NAND oscillator; latched at round start
- cnt_val  in  CNT_W  registered edge-counter value
- osc_en  out  2  one-hot oscillator enable, or 0
- osc_sel  out  1  counter mux select (0 = inverter, 1 = NAND)
- cnt_en  out  1  counter gate
- cnt_clr  out  1  counter synchronous clear
- res_value  out  CNT_W  averaged count
- res_osc  out  1  oscillator that produced `res_value`
- res_sat  out  1  some sample in this average equalled all-ones
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, SETTLE, COUNT, CAPTURE, REPORT, GAP.
- IDLE: all outputs 0. Round starts when (`start` | `auto_mode`) = 1 and the latched `osc_mask` ≠ 0.
  - If the mask is 0, stay in IDLE.
  - On round start, latch the mask and select the lowest set bit.
- SETTLE: `osc_en` is one-hot on the current oscillator. `osc_sel` = current index. `cnt_clr` = 1. Lasts SETTLE_CYCLES cycles, then → COUNT.
- COUNT: `cnt_en` = 1 for exactly WIN_CYCLES cycles, then → CAPTURE.
- CAPTURE: one cycle with `cnt_en` = 0 and `cnt_clr` = 1.
  - Update the accumulator: acc += `cnt_val`.
  - The sticky saturation flag is set if `cnt_val` = 2^CNT_W−1.
  - Increment the sample count.
  - If the sample count < 2^LOG2_AVG → COUNT; otherwise → REPORT.
- Accumulator: width CNT_W+LOG2_AVG, no overflow possible. Result = acc >> LOG2_AVG (truncating).
- REPORT: `res_value`, `res_osc`, `res_sat` are registered and held stable while `res_valid` = 1.
  - `osc_en` stays on.
  - Transfer occurs on the cycle `res_valid` & `res_ready`. On that cycle clear the accumulator, sample count and saturation flag, and `res_valid` drops next cycle.
  - Then:
    - If the next higher mask bit is set → SETTLE for that oscillator (full settle; `osc_en` switches in the same edge).
    - Else, if `auto_mode` = 1 → GAP.
    - Else → IDLE.
- GAP: `osc_en` = 0 for IDLE_CYCLES cycles, then re-latch `osc_mask` and start a new round.
  - If `auto_mode` has dropped, or the new mask is 0, → IDLE.
- `abort`: → IDLE on the next edge and clear all state.
  - A pending result is discarded.
  - Has priority over every transition, including a handshake in the same cycle.
- `osc_mask` changes mid-round are ignored until the next round start.

## Timing
- Reset: after `rst` high at an edge, all outputs = 0 and state = IDLE.
  - Reset mid-window drops `cnt_en` and `osc_en` on that edge.
  - Reset overrides `abort` and the handshake.
- Let `start` be sampled high at edge 0. With N = 2^LOG2_AVG:
  - SETTLE occupies cycles 1..S (S = SETTLE_CYCLES).
  - The first COUNT occupies cycles S+1..S+W (W = WIN_CYCLES).
  - CAPTURE is at S+W+1.
  - `res_valid` first rises at cycle 1+S+N·(W+1).
- `cnt_val` is sampled in CAPTURE, which is one cycle after the last `cnt_en`. The counter must register its value within one cycle.
- `res_ready` may be high before `res_valid`. The handshake then completes in the first REPORT cycle, so `res_valid` is high for exactly 1 cycle.
- In two-oscillator mode, the second SETTLE begins on the cycle after the handshake.

## Structure
- Package `meas_pkg` holds:
  - the state enum (IDLE, SETTLE, COUNT, CAPTURE, REPORT, GAP)
  - oscillator index constants OSC_INV = 0, OSC_NAND = 1
  - the mask width constant NUM_OSC = 2
- Sub-module `meas_timer`: loadable down-counter with a done pulse. Its width is the clog2 of the largest of WIN/SETTLE/IDLE. One instance is reused for SETTLE, COUNT and GAP.

## Test plan
Bench parameters: W = 8, S = 4, LOG2_AVG = 2, IDLE = 5, CNT_W = 10. `cnt_val` is driven by a counter model.
- Single inverter round, model adds 25 edges per window, mask = 01, `res_ready` = 1 → `osc_en` = 01 from cycle 1; `res_valid` at cycle 41 for 1 cycle; `res_value` = 25, `res_osc` = 0, `res_sat` = 0; IDLE at cycle 42.
- Both oscillators, samples inverter 10,11,12,13 / NAND 40,40,40,41, mask = 11 → results 11 (truncated 46/4) with `res_osc` = 0, then 40 with `res_osc` = 1; NAND SETTLE starts the cycle after the first handshake.
- Backpressure: hold `res_ready` = 0 for 20 cycles in REPORT → `res_value`/`res_osc`/`res_valid` stable and `cnt_en` = 0 throughout; release → single transfer.
- Saturation: one sample = 1023, others 0 → `res_value` = 255, `res_sat` = 1; `res_sat` cleared in the next round.
- Auto mode: mask = 10, `auto_mode` = 1 → `osc_en` = 00 for exactly 5 GAP cycles between handshakes; drop `auto_mode` during GAP → IDLE at GAP end.
- Abort and reset in cycle 20 (mid-COUNT), separately → all outputs 0 next cycle, no `res_valid`; `start` with mask = 00 → `busy` stays 0.
